// File: rtl/pipe_pkg.sv
// Shared definitions for the MEM pipeline stage: FSM encoding and alignment mask.
package pipe_pkg;

    typedef enum logic {
        MS_IDLE = 1'b0,
        MS_BUSY = 1'b1
    } ms_state_e;

    // Low address bits that must be zero for a word access.
    localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

endpackage

// File: rtl/pipemem_stage_if.sv
// Data-memory port between the MEM stage (master) and dmem (slave).
//
// Handshake: dmem_req is held high from the first request cycle until the
// cycle in which dmem_ack is seen; dmem_we/dmem_addr/dmem_wdata are stable
// for that whole window. dmem_ack is a one-cycle completion strobe, and
// dmem_rdata is valid only in the ack cycle of a load. An ack while dmem_req
// is low carries no meaning and is ignored by the master.
interface pipemem_stage_if;

    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_ack, dmem_rdata
    );

endinterface

// File: rtl/pipemem_wdog.sv
// Watchdog for an outstanding dmem request: counts request cycles and flags
// the last permitted cycle so the stage can abandon the access.
module pipemem_wdog #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic clock,
    input  logic reset,
    input  logic en_i,          // a request is outstanding this cycle
    input  logic clr_i,         // the request completes this cycle
    output logic timeout_now_o  // last cycle without ack: give up
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // An ack arriving in the final cycle wins over the timeout.
    assign timeout_now_o = en_i & ~clr_i & (cnt_q == LAST);

    // Next count: clear on completion/abandon, otherwise count up and saturate.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || timeout_now_o) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pipemem_stage.sv
// MEM stage of the 5-stage MIPS pipeline: EX/MEM register plus a lw/sw
// access to a variable-latency data memory. Upstream stages are frozen while
// an access is outstanding; the completing cycle never stalls.
module pipemem_stage
    import pipe_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        evalid,
    input  logic        ewreg,
    input  logic        em2reg,
    input  logic        ewmem,
    input  logic [31:0] ealu,
    input  logic [31:0] eb,
    input  logic [4:0]  ern,
    output logic        stall_mem,
    output logic        mvalid,
    output logic        mwreg,
    output logic        mm2reg,
    output logic [4:0]  mrn,
    output logic [31:0] malu,
    output logic [31:0] mmo,
    output logic        merr,
    output ms_state_e   dbg_state,
    pipemem_stage_if.master dmem
);

    // M register
    logic        mv_q, mwreg_q, mm2reg_q, mwmem_q;
    logic [31:0] malu_q, mb_q;
    logic [4:0]  mrn_q;

    ms_state_e state_q, state_d;
    logic      merr_q;

    logic memop, misalign, req, ack_v, timeout_now;

    assign memop    = mv_q & (mm2reg_q | mwmem_q);
    assign misalign = memop & ((malu_q[1:0] & WORD_ALIGN_MASK) != 2'b00);
    // Request goes out combinationally in the cycle the M register is loaded.
    assign req      = (state_q == MS_BUSY) | (memop & ~misalign);
    assign ack_v    = req & dmem.dmem_ack;

    pipemem_wdog #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_wdog (
        .clock         (clock),
        .reset         (reset),
        .en_i          (req),
        .clr_i         (ack_v),
        .timeout_now_o (timeout_now)
    );

    assign stall_mem = memop & ~misalign & ~ack_v & ~timeout_now;
    assign mvalid    = mv_q & ~stall_mem;
    assign mwreg     = mwreg_q & mvalid & ~(misalign | timeout_now);
    assign mm2reg    = mm2reg_q;
    assign mrn       = mrn_q;
    assign malu      = malu_q;
    assign mmo       = ack_v ? dmem.dmem_rdata : 32'h0;
    assign merr      = merr_q;
    assign dbg_state = state_q;

    assign dmem.dmem_req   = req;
    assign dmem.dmem_we    = req & mwmem_q;
    assign dmem.dmem_addr  = malu_q;
    assign dmem.dmem_wdata = mb_q;

    // Next state: leave IDLE only if the access did not finish in its first cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            MS_IDLE: if (req && !ack_v && !timeout_now) state_d = MS_BUSY;
            MS_BUSY: if (ack_v || timeout_now)          state_d = MS_IDLE;
            default: state_d = MS_IDLE;
        endcase
    end

    // FSM state and sticky error flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= MS_IDLE;
            merr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (misalign || timeout_now) merr_q <= 1'b1;
        end
    end

    // EX/MEM register, frozen while an access is outstanding.
    always_ff @(posedge clock) begin
        if (reset) begin
            mv_q     <= 1'b0;
            mwreg_q  <= 1'b0;
            mm2reg_q <= 1'b0;
            mwmem_q  <= 1'b0;
            malu_q   <= 32'h0;
            mb_q     <= 32'h0;
            mrn_q    <= 5'h0;
        end else if (!stall_mem) begin
            mv_q     <= evalid;
            mwreg_q  <= ewreg;
            mm2reg_q <= em2reg;
            mwmem_q  <= ewmem;
            malu_q   <= ealu;
            mb_q     <= eb;
            mrn_q    <= ern;
        end
    end

endmodule

// File: tb/tb_pipemem_stage.sv
// Bench for pipemem_stage: in-order instruction stream against a sequential
// reference model (retire queue, access queue, reference memory) and a
// latency-programmable dmem responder.
module tb_pipemem_stage;
  import pipe_pkg::*;

  localparam int TIMEOUT = 16;
  localparam int NEVER   = 99;

  logic        clock = 1'b0;
  logic        reset;
  logic        evalid, ewreg, em2reg, ewmem;
  logic [31:0] ealu, eb;
  logic [4:0]  ern;
  logic        stall_mem, mvalid, mwreg, mm2reg, merr;
  logic [4:0]  mrn;
  logic [31:0] malu, mmo;
  ms_state_e   dbg_state;

  pipemem_stage_if dmem_bus ();

  pipemem_stage #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
    .clock(clock), .reset(reset),
    .evalid(evalid), .ewreg(ewreg), .em2reg(em2reg), .ewmem(ewmem),
    .ealu(ealu), .eb(eb), .ern(ern),
    .stall_mem(stall_mem), .mvalid(mvalid), .mwreg(mwreg), .mm2reg(mm2reg),
    .mrn(mrn), .malu(malu), .mmo(mmo), .merr(merr), .dbg_state(dbg_state),
    .dmem(dmem_bus)
  );

  // clock / reset
  always #5 clock = ~clock;

  typedef struct {
    logic v, wreg, m2reg, wmem;
    logic [31:0] alu, b;
    logic [4:0] rn;
    int lat;
  } instr_t;

  typedef struct {
    logic wreg, m2reg;
    logic [4:0] rn;
    logic [31:0] alu, mmo;
    bit chk_mmo;
  } ret_t;

  typedef struct {
    logic [31:0] addr, wdata;
    logic we;
  } acc_t;

  instr_t stim_q[$];
  ret_t   exp_ret_q[$];
  acc_t   exp_acc_q[$];
  int     lat_q[$];
  logic [31:0] ref_mem [64];
  logic [31:0] dmem    [64];
  bit     exp_merr;

  int n_tests = 0;
  int n_fail  = 0;
  int stall_cycles, req_cycles, we_cycles;

  bit   pend;
  int   pcnt;
  acc_t pacc;

  function automatic instr_t mk(input logic v, wreg, m2reg, wmem,
                                input logic [31:0] alu, b, input logic [4:0] rn,
                                input int lat);
    instr_t t;
    t.v = v; t.wreg = wreg; t.m2reg = m2reg; t.wmem = wmem;
    t.alu = alu; t.b = b; t.rn = rn; t.lat = lat;
    return t;
  endfunction

  // driver tasks
  task automatic drive_e(input instr_t t);
    evalid = t.v; ewreg = t.wreg; em2reg = t.m2reg; ewmem = t.wmem;
    ealu = t.alu; eb = t.b; ern = t.rn;
  endtask

  // Reference model: sequential semantics of one instruction entering MEM.
  task automatic model_issue(input instr_t t);
    ret_t r;
    acc_t a;
    logic [5:0] idx;
    bit memop;
    if (!t.v) return;
    memop = t.m2reg || t.wmem;
    idx = t.alu[7:2];
    r.rn = t.rn; r.alu = t.alu; r.m2reg = t.m2reg; r.mmo = 32'h0; r.chk_mmo = 1;
    r.wreg = t.wreg;
    if (memop && (t.alu % 4) != 0) begin
      exp_merr = 1; r.wreg = 0;
    end else if (memop && t.lat >= TIMEOUT) begin
      exp_merr = 1; r.wreg = 0;
      lat_q.push_back(t.lat);
    end else if (memop) begin
      lat_q.push_back(t.lat);
      a.addr = t.alu; a.we = t.wmem; a.wdata = t.b;
      exp_acc_q.push_back(a);
      if (t.wmem) begin
        ref_mem[idx] = t.b;
        r.chk_mmo = 0;
      end else begin
        r.mmo = ref_mem[idx];
      end
    end
    exp_ret_q.push_back(r);
  endtask

  task automatic next_instr(output instr_t t);
    if (stim_q.size() > 0) t = stim_q.pop_front();
    else t = mk(0, 0, 0, 0, 32'h0, 32'h0, 5'h0, 0);
    model_issue(t);
  endtask

  task automatic do_reset();
    instr_t b;
    b = mk(0, 0, 0, 0, 32'h0, 32'h0, 5'h0, 0);
    reset = 1'b1;
    drive_e(b);
    dmem_bus.dmem_ack = 1'b0;
    dmem_bus.dmem_rdata = 32'h0;
    stim_q.delete(); exp_ret_q.delete(); exp_acc_q.delete(); lat_q.delete();
    pend = 0; exp_merr = 0;
    for (int i = 0; i < 64; i++) begin
      ref_mem[i] = 32'hA500_0000 + i * 32'h0001_0203;
      dmem[i]    = ref_mem[i];
    end
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  // Engine: feeds stim_q, models dmem, and checks every retirement/access.
  task automatic run(input int budget);
    instr_t cur;
    ret_t   r;
    acc_t   a;
    int     cyc;
    bit     consumed;
    logic [5:0] idx;
    cyc = 0;
    stall_cycles = 0; req_cycles = 0; we_cycles = 0;
    next_instr(cur);
    drive_e(cur);
    while ((stim_q.size() > 0 || exp_ret_q.size() > 0) && cyc < budget) begin
      @(negedge clock);
      dmem_bus.dmem_ack = 1'b0;
      dmem_bus.dmem_rdata = $urandom;
      if (dmem_bus.dmem_req) begin
        if (!pend) begin
          pend = 1;
          pacc.addr = dmem_bus.dmem_addr; pacc.we = dmem_bus.dmem_we;
          pacc.wdata = dmem_bus.dmem_wdata;
          n_tests++;
          if (lat_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_req: got addr %h, required no request", pacc.addr);
            pcnt = 0;
          end else pcnt = lat_q.pop_front();
        end else begin
          n_tests++;
          if (dmem_bus.dmem_addr !== pacc.addr || dmem_bus.dmem_we !== pacc.we ||
              dmem_bus.dmem_wdata !== pacc.wdata) begin
            n_fail++;
            $display("FAIL req_hold: got %h/%b/%h, required %h/%b/%h",
                     dmem_bus.dmem_addr, dmem_bus.dmem_we, dmem_bus.dmem_wdata,
                     pacc.addr, pacc.we, pacc.wdata);
          end
        end
        if (pcnt == 0) begin
          pend = 0;
          dmem_bus.dmem_ack = 1'b1;
          idx = pacc.addr[7:2];
          if (pacc.we) dmem[idx] = pacc.wdata;
          else dmem_bus.dmem_rdata = dmem[idx];
          n_tests++;
          if (exp_acc_q.size() == 0) begin
            n_fail++;
            $display("FAIL extra_access: got addr %h, required none", pacc.addr);
          end else begin
            a = exp_acc_q.pop_front();
            if (a.addr !== pacc.addr || a.we !== pacc.we || (a.we && a.wdata !== pacc.wdata)) begin
              n_fail++;
              $display("FAIL access: got %h/%b/%h, required %h/%b/%h",
                       pacc.addr, pacc.we, pacc.wdata, a.addr, a.we, a.wdata);
            end
          end
        end else pcnt--;
      end else pend = 0;
      #1;
      if (dmem_bus.dmem_req) req_cycles++;
      if (dmem_bus.dmem_we) we_cycles++;
      if (stall_mem) stall_cycles++;
      n_tests++;
      if (!mvalid && mwreg) begin
        n_fail++;
        $display("FAIL mwreg_gate: got mwreg=1 with mvalid=0, required 0");
      end
      if (mvalid) begin
        if (pend && !dmem_bus.dmem_ack) pend = 0;
        n_tests++;
        if (exp_ret_q.size() == 0) begin
          n_fail++;
          $display("FAIL spurious_retire: got mvalid=1 malu=%h, required no retirement", malu);
        end else begin
          r = exp_ret_q.pop_front();
          if (mwreg !== r.wreg || mrn !== r.rn || malu !== r.alu || mm2reg !== r.m2reg ||
              (r.chk_mmo && mmo !== r.mmo)) begin
            n_fail++;
            $display("FAIL retire: got wreg=%b rn=%0d alu=%h m2reg=%b mmo=%h, required wreg=%b rn=%0d alu=%h m2reg=%b mmo=%h",
                     mwreg, mrn, malu, mm2reg, mmo, r.wreg, r.rn, r.alu, r.m2reg, r.mmo);
          end
        end
      end
      consumed = !stall_mem;
      @(posedge clock);
      #1;
      dmem_bus.dmem_ack = 1'b0;
      if (consumed) begin
        next_instr(cur);
        drive_e(cur);
      end
      cyc++;
    end
    n_tests++;
    if (cyc >= budget) begin
      n_fail++;
      $display("FAIL run_budget: got %0d cycles with %0d pending, required completion", cyc, exp_ret_q.size());
    end
    n_tests++;
    if (exp_acc_q.size() != 0) begin
      n_fail++;
      $display("FAIL lost_access: got %0d accesses missing, required 0", exp_acc_q.size());
    end
    n_tests++;
    if (merr !== exp_merr) begin
      n_fail++;
      $display("FAIL merr: got %b, required %b", merr, exp_merr);
    end
  endtask

  task automatic test_reset();
    instr_t j;
    reset = 1'b1;
    j = mk(1, 1, 1, 0, $urandom, $urandom, 5'($urandom_range(0, 31)), 0);
    drive_e(j);
    dmem_bus.dmem_ack = 1'b0;
    dmem_bus.dmem_rdata = $urandom;
    repeat (3) @(posedge clock);
    #1;
    n_tests++;
    if ({stall_mem, mvalid, mwreg, mm2reg, merr, dmem_bus.dmem_req, dmem_bus.dmem_we} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_ctl: got %b, required 0000000",
               {stall_mem, mvalid, mwreg, mm2reg, merr, dmem_bus.dmem_req, dmem_bus.dmem_we});
    end
    n_tests++;
    if ({mrn, malu, mmo, dmem_bus.dmem_addr, dmem_bus.dmem_wdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got rn=%0d alu=%h mmo=%h addr=%h wdata=%h, required all 0",
               mrn, malu, mmo, dmem_bus.dmem_addr, dmem_bus.dmem_wdata);
    end
    n_tests++;
    if (dbg_state !== MS_IDLE) begin
      n_fail++;
      $display("FAIL reset_state: got %0d, required IDLE", dbg_state);
    end
    do_reset();
  endtask

  task automatic test_lw_latency();
    do_reset();
    ref_mem[4] = 32'h1234_5678;
    dmem[4]    = 32'h1234_5678;
    stim_q.push_back(mk(1, 1, 1, 0, 32'h10, 32'h0, 5'd8, 3));
    run(100);
    n_tests++;
    if (stall_cycles != 3 || req_cycles != 4) begin
      n_fail++;
      $display("FAIL lw_latency: got stall=%0d req=%0d, required stall=3 req=4", stall_cycles, req_cycles);
    end
  endtask

  task automatic test_sw_zero_wait();
    do_reset();
    stim_q.push_back(mk(1, 0, 0, 1, 32'h40, 32'hCAFE_F00D, 5'd0, 0));
    run(100);
    n_tests++;
    if (stall_cycles != 0 || req_cycles != 1 || we_cycles != 1) begin
      n_fail++;
      $display("FAIL sw_zero_wait: got stall=%0d req=%0d we=%0d, required 0/1/1",
               stall_cycles, req_cycles, we_cycles);
    end
  endtask

  task automatic test_misalign();
    do_reset();
    stim_q.push_back(mk(1, 1, 1, 0, 32'h13, 32'h0, 5'd5, 0));
    run(100);
    n_tests++;
    if (stall_cycles != 0 || req_cycles != 0) begin
      n_fail++;
      $display("FAIL misalign: got stall=%0d req=%0d, required 0/0", stall_cycles, req_cycles);
    end
    stim_q.push_back(mk(1, 1, 0, 0, 32'h7, 32'h0, 5'd3, 0));
    run(100);
  endtask

  task automatic test_timeout();
    do_reset();
    stim_q.push_back(mk(1, 1, 1, 0, 32'h20, 32'h0, 5'd6, NEVER));
    run(100);
    n_tests++;
    if (stall_cycles != TIMEOUT - 1 || req_cycles != TIMEOUT) begin
      n_fail++;
      $display("FAIL timeout: got stall=%0d req=%0d, required %0d/%0d",
               stall_cycles, req_cycles, TIMEOUT - 1, TIMEOUT);
    end
    n_tests++;
    if (dmem_bus.dmem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_drop: got req=%b, required 0", dmem_bus.dmem_req);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    do_reset();
    d = $urandom;
    stim_q.push_back(mk(1, 1, 0, 0, 32'h7, 32'h0, 5'd2, 0));
    stim_q.push_back(mk(1, 0, 0, 1, 32'h80, d, 5'd0, 1));
    stim_q.push_back(mk(1, 1, 1, 0, 32'h80, 32'h0, 5'd9, 1));
    run(100);
    n_tests++;
    if (stall_cycles != 2 || req_cycles != 4) begin
      n_fail++;
      $display("FAIL back_to_back: got stall=%0d req=%0d, required 2/4", stall_cycles, req_cycles);
    end
  endtask

  task automatic test_reset_busy();
    do_reset();
    drive_e(mk(1, 1, 1, 0, 32'h24, 32'h0, 5'd4, 0));
    @(posedge clock);
    #1;
    drive_e(mk(0, 0, 0, 0, 32'h0, 32'h0, 5'h0, 0));
    @(posedge clock);
    #1;
    n_tests++;
    if (dbg_state !== MS_BUSY || dmem_bus.dmem_req !== 1'b1 || stall_mem !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_entry: got state=%0d req=%b stall=%b, required BUSY/1/1",
               dbg_state, dmem_bus.dmem_req, stall_mem);
    end
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    dmem_bus.dmem_ack = 1'b1;
    dmem_bus.dmem_rdata = 32'hDEAD_BEEF;
    #1;
    n_tests++;
    if ({stall_mem, mvalid, mwreg, mm2reg, merr, dmem_bus.dmem_req, dmem_bus.dmem_we} !== 7'b0 ||
        mmo !== 32'h0 || malu !== 32'h0 || mrn !== 5'h0) begin
      n_fail++;
      $display("FAIL reset_busy: got ctl=%b mmo=%h alu=%h rn=%0d, required all 0",
               {stall_mem, mvalid, mwreg, mm2reg, merr, dmem_bus.dmem_req, dmem_bus.dmem_we},
               mmo, malu, mrn);
    end
    @(posedge clock);
    #1;
    dmem_bus.dmem_ack = 1'b0;
    n_tests++;
    if (dbg_state !== MS_IDLE || merr !== 1'b0 || mvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL late_ack: got state=%0d merr=%b mvalid=%b, required IDLE/0/0",
               dbg_state, merr, mvalid);
    end
  endtask

  task automatic test_random();
    int k;
    logic [31:0] a;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      k = $urandom_range(0, 9);
      a = 32'($urandom_range(0, 15)) * 4;
      case (k)
        0, 1: stim_q.push_back(mk(0, $urandom, $urandom, $urandom, $urandom, $urandom, 5'($urandom), 0));
        2, 3: stim_q.push_back(mk(1, 1, 0, 0, $urandom, $urandom, 5'($urandom), 0));
        4, 5, 6: stim_q.push_back(mk(1, 1, 1, 0, a, 32'h0, 5'($urandom), $urandom_range(0, 3)));
        7, 8: stim_q.push_back(mk(1, 0, 0, 1, a, $urandom, 5'h0, $urandom_range(0, 3)));
        default: stim_q.push_back(mk(1, 1, 1, 0, a + 32'($urandom_range(1, 3)), 32'h0, 5'($urandom), 0));
      endcase
    end
    run(5000);
  endtask

  initial begin
    test_reset();
    test_lw_latency();
    test_sw_zero_wait();
    test_misalign();
    test_timeout();
    test_back_to_back();
    test_reset_busy();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
